// File: rtl/elasticmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package : elasticmem_arb_pkg
// Summary : shared types and width helpers for the elasticmem read arbiter
// Rev     : 1.0
// ============================================================================
package elasticmem_arb_pkg;

    // Width helper that never collapses to zero bits for tiny parameters
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_N_REQ = 4;
    localparam int TAG_W_DEF = clog2_min1(DEF_N_REQ);

    typedef logic [TAG_W_DEF-1:0] tag_t;

    typedef enum logic [0:0] {
        ST_OPEN = 1'b0,
        ST_HELD = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/arb_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module  : arb_tag_fifo
// Summary : register-based in-order FIFO of requester tags
// Rev     : 1.0
// ============================================================================
module arb_tag_fifo
    import elasticmem_arb_pkg::*;
#(
    parameter  int W     = 2,
    parameter  int DEPTH = 8,
    localparam int CW    = clog2_min1(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_tag,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    localparam int PW = clog2_min1(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == CW'(DEPTH));
    assign count  = r_count;
    assign head   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_tag;
                r_wr_ptr        <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/elasticmem_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : elasticmem_rd_arbiter
// Summary : round-robin sharing of one elasticmem read port, in-order tag return
// Rev     : 1.0
// ============================================================================
module elasticmem_rd_arbiter
    import elasticmem_arb_pkg::*;
#(
    parameter  int WIDTH           = 32,
    parameter  int DEPTH           = 512,
    parameter  int N_REQ           = 4,
    parameter  int MAX_OUTSTANDING = 8,
    localparam int AW              = clog2_min1(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0][AW-1:0]  req_addr,
    input  logic [N_REQ-1:0]          req_vld,
    output logic [N_REQ-1:0]          req_rdy,
    output logic [WIDTH-1:0]          rsp_dat,
    output logic [N_REQ-1:0]          rsp_vld,
    input  logic [N_REQ-1:0]          rsp_rdy,
    output logic [AW-1:0]             mem_rd_addr,
    output logic                      mem_rd_req_vld,
    input  logic                      mem_rd_req_rdy,
    input  logic [WIDTH-1:0]          mem_rd_dat,
    input  logic                      mem_rd_dat_vld,
    output logic                      mem_rd_dat_rdy
);

    localparam int TAG_W = clog2_min1(N_REQ);
    localparam int CW    = clog2_min1(MAX_OUTSTANDING + 1);

    arb_state_t       r_state;
    logic [TAG_W-1:0] r_rr;
    logic [TAG_W-1:0] r_hold_idx;
    logic [TAG_W-1:0] w_arb_idx;
    logic [TAG_W-1:0] w_gnt;
    logic [TAG_W-1:0] w_gnt_next;
    logic [TAG_W-1:0] w_head;
    logic [CW-1:0]    w_count;
    logic             w_found;
    logic             w_credit;
    logic             w_issue;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic             w_fwd;

    // First valid requester at or after the round-robin pointer
    always_comb begin
        w_arb_idx = r_rr;
        w_found   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            int s;
            s = int'(r_rr) + k;
            if (s >= N_REQ) begin
                s = s - N_REQ;
            end
            if (!w_found && req_vld[s]) begin
                w_found   = 1'b1;
                w_arb_idx = TAG_W'(s);
            end
        end
    end

    assign w_gnt          = (r_state == ST_HELD) ? r_hold_idx : w_arb_idx;
    assign w_gnt_next     = (w_gnt == TAG_W'(N_REQ - 1)) ? '0 : w_gnt + 1'b1;
    assign w_credit       = (w_count < CW'(MAX_OUTSTANDING));
    assign mem_rd_req_vld = w_credit && ((r_state == ST_HELD) || (|req_vld));
    assign mem_rd_addr    = req_addr[w_gnt];
    assign w_issue        = mem_rd_req_vld && mem_rd_req_rdy;

    always_comb begin
        req_rdy = '0;
        if (w_issue) begin
            req_rdy[w_gnt] = 1'b1;
        end
    end

    assign w_fwd          = !w_empty;
    assign rsp_dat        = mem_rd_dat;
    assign mem_rd_dat_rdy = w_fwd && rsp_rdy[w_head];
    assign w_pop          = mem_rd_dat_vld && mem_rd_dat_rdy;

    always_comb begin
        rsp_vld = '0;
        if (mem_rd_dat_vld && w_fwd) begin
            rsp_vld[w_head] = 1'b1;
        end
    end

    // A stalled request freezes the grant so address and valid stay stable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_OPEN;
            r_rr       <= '0;
            r_hold_idx <= '0;
        end else begin
            case (r_state)
                ST_OPEN: begin
                    if (w_issue) begin
                        r_rr <= w_gnt_next;
                    end else if (mem_rd_req_vld) begin
                        r_state    <= ST_HELD;
                        r_hold_idx <= w_gnt;
                    end
                end
                ST_HELD: begin
                    if (w_issue) begin
                        r_state <= ST_OPEN;
                        r_rr    <= w_gnt_next;
                    end
                end
                default: r_state <= ST_OPEN;
            endcase
        end
    end

    arb_tag_fifo #(
        .W     (TAG_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_issue),
        .push_tag (w_gnt),
        .pop      (w_pop),
        .head     (w_head),
        .empty    (w_empty),
        .full     (w_full),
        .count    (w_count)
    );

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        !(mem_rd_dat_vld && w_empty));

    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(w_issue && w_full));

endmodule
`default_nettype wire

// File: tb/tb_elasticmem_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_elasticmem_rd_arbiter
// Summary : self-checking bench with latency memory model and scoreboard
// Rev     : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_elasticmem_rd_arbiter;

    localparam int N    = 4;
    localparam int W    = 32;
    localparam int AW   = 9;
    localparam int MAXO = 8;
    localparam int LAT  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    logic [N-1:0][AW-1:0] req_addr;
    logic [N-1:0]         req_vld, req_rdy, rsp_vld, rsp_rdy;
    logic [W-1:0]         rsp_dat;
    logic [W-1:0]         mem_rd_dat = '0;
    logic [AW-1:0]        mem_rd_addr;
    logic                 mem_rd_req_vld, mem_rd_req_rdy, mem_rd_dat_rdy;
    logic                 mem_rd_dat_vld = 1'b0;

    logic [N-1:0][AW-1:0] b_req_addr;
    logic [N-1:0]         b_req_vld, b_req_rdy, b_rsp_vld, b_rsp_rdy;
    logic [W-1:0]         b_rsp_dat, b_mem_rd_dat;
    logic [AW-1:0]        b_mem_rd_addr;
    logic                 b_mem_rd_req_vld, b_mem_rd_req_rdy, b_mem_rd_dat_vld, b_mem_rd_dat_rdy;

    elasticmem_rd_arbiter #(.WIDTH(W), .DEPTH(512), .N_REQ(N), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst), .req_addr(req_addr), .req_vld(req_vld), .req_rdy(req_rdy),
        .rsp_dat(rsp_dat), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
        .mem_rd_addr(mem_rd_addr), .mem_rd_req_vld(mem_rd_req_vld), .mem_rd_req_rdy(mem_rd_req_rdy),
        .mem_rd_dat(mem_rd_dat), .mem_rd_dat_vld(mem_rd_dat_vld), .mem_rd_dat_rdy(mem_rd_dat_rdy));

    elasticmem_rd_arbiter #(.WIDTH(W), .DEPTH(512), .N_REQ(N), .MAX_OUTSTANDING(2)) dut2 (
        .clk(clk), .rst(rst), .req_addr(b_req_addr), .req_vld(b_req_vld), .req_rdy(b_req_rdy),
        .rsp_dat(b_rsp_dat), .rsp_vld(b_rsp_vld), .rsp_rdy(b_rsp_rdy),
        .mem_rd_addr(b_mem_rd_addr), .mem_rd_req_vld(b_mem_rd_req_vld), .mem_rd_req_rdy(b_mem_rd_req_rdy),
        .mem_rd_dat(b_mem_rd_dat), .mem_rd_dat_vld(b_mem_rd_dat_vld), .mem_rd_dat_rdy(b_mem_rd_dat_rdy));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory model: Mem[a] = a + 0x100, fixed read latency, in-order return
    typedef struct { logic [AW-1:0] a; int t; } mreq_t;
    mreq_t mem_q[$];
    int    cyc = 0;

    always @(posedge clk) begin
        if (rst) begin
            mem_q.delete();
            mem_rd_dat_vld <= 1'b0;
            mem_rd_dat     <= '0;
        end else begin
            if (mem_rd_dat_vld && mem_rd_dat_rdy) void'(mem_q.pop_front());
            if (mem_rd_req_vld && mem_rd_req_rdy) mem_q.push_back('{a: mem_rd_addr, t: cyc + LAT});
            if (mem_q.size() > 0 && mem_q[0].t <= cyc) begin
                mem_rd_dat_vld <= 1'b1;
                mem_rd_dat     <= W'(mem_q[0].a) + 32'h100;
            end else begin
                mem_rd_dat_vld <= 1'b0;
            end
        end
        cyc <= cyc + 1;
    end

    // Reference model: round-robin grant, credit limit, in-order response queue
    typedef struct { int idx; logic [AW-1:0] a; } exp_t;
    exp_t         sb[$];
    int           m_rr = 0, m_lidx = 0, mon_g, mon_h, mon_j;
    bit           m_lock = 0;
    logic         mon_ev, mon_edrdy;
    logic [N-1:0] mon_erdy, mon_erv, acc_mask = '0;
    int           rx_cnt [N];
    logic [W-1:0] rx0_dat[$];
    int           rx0_cyc[$];

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_rr = 0; m_lock = 0; m_lidx = 0; acc_mask = '0;
        end else begin
            mon_g = -1;
            if (m_lock) mon_g = m_lidx;
            else for (int k = 0; k < N; k++) begin
                mon_j = (m_rr + k) % N;
                if (mon_g < 0 && req_vld[mon_j]) mon_g = mon_j;
            end
            mon_ev = (sb.size() < MAXO) && (m_lock || (req_vld != '0));
            chk("mem_rd_req_vld", mem_rd_req_vld, mon_ev);
            mon_erdy = (mon_ev && mem_rd_req_rdy && mon_g >= 0) ? (N'(1) << mon_g) : '0;
            chk("req_rdy", req_rdy, mon_erdy);
            if (mon_ev && mon_g >= 0) chk("mem_rd_addr", mem_rd_addr, req_addr[mon_g]);
            acc_mask = req_rdy;
            mon_h     = (sb.size() > 0) ? sb[0].idx : 0;
            mon_erv   = (mem_rd_dat_vld && sb.size() > 0) ? (N'(1) << mon_h) : '0;
            mon_edrdy = (sb.size() > 0) && rsp_rdy[mon_h];
            chk("rsp_vld", rsp_vld, mon_erv);
            chk("mem_rd_dat_rdy", mem_rd_dat_rdy, mon_edrdy);
            if (mem_rd_dat_vld && mon_edrdy) begin
                chk("rsp_dat", rsp_dat, W'(sb[0].a) + 32'h100);
                rx_cnt[mon_h]++;
                if (mon_h == 0) begin
                    rx0_dat.push_back(rsp_dat);
                    rx0_cyc.push_back(cyc);
                end
                void'(sb.pop_front());
            end
            if (mon_ev && mem_rd_req_rdy && mon_g >= 0) begin
                sb.push_back('{idx: mon_g, a: req_addr[mon_g]});
                m_rr = (mon_g + 1) % N;
                m_lock = 0;
            end else if (mon_ev && mon_g >= 0) begin
                m_lock = 1;
                m_lidx = mon_g;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct { logic [N-1:0] vld; logic mrdy; logic [N-1:0] exp_rdy; logic exp_mvld; } vec_t;
    vec_t tbl [12];

    initial begin
        int k [N];
        int issues, base;
        tbl[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0};
        tbl[1]  = '{4'b1010, 1'b1, 4'b0010, 1'b1};
        tbl[2]  = '{4'b1011, 1'b1, 4'b1000, 1'b1};
        tbl[3]  = '{4'b0011, 1'b1, 4'b0001, 1'b1};
        tbl[4]  = '{4'b0101, 1'b0, 4'b0000, 1'b1};
        tbl[5]  = '{4'b0111, 1'b1, 4'b0100, 1'b1};
        tbl[6]  = '{4'b0011, 1'b1, 4'b0001, 1'b1};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0010, 1'b1};
        tbl[8]  = '{4'b1111, 1'b1, 4'b0100, 1'b1};
        tbl[9]  = '{4'b1111, 1'b1, 4'b1000, 1'b1};
        tbl[10] = '{4'b0001, 1'b1, 4'b0001, 1'b1};
        tbl[11] = '{4'b0001, 1'b1, 4'b0001, 1'b1};

        for (int i = 0; i < N; i++) rx_cnt[i] = 0;
        req_vld = '0; req_addr = '0; rsp_rdy = '1; mem_rd_req_rdy = 1'b1;
        b_req_vld = '0; b_req_addr = '0; b_rsp_rdy = '0; b_mem_rd_req_rdy = 1'b1;
        b_mem_rd_dat_vld = 1'b0; b_mem_rd_dat = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("reset req_rdy", req_rdy, '0);
        chk("reset rsp_vld", rsp_vld, '0);
        chk("reset mem_rd_req_vld", mem_rd_req_vld, 1'b0);
        chk("reset mem_rd_dat_rdy", mem_rd_dat_rdy, 1'b0);
        chk("reset count", dut.w_count, '0);
        rst = 1'b0;

        // Arbitration vectors, applied one per cycle from rr = 0
        for (int i = 0; i < N; i++) req_addr[i] = AW'(i * 16 + 3);
        for (int e = 0; e < 12; e++) begin
            req_vld = tbl[e].vld;
            mem_rd_req_rdy = tbl[e].mrdy;
            #1;
            chk($sformatf("vec%0d req_rdy", e), req_rdy, tbl[e].exp_rdy);
            chk($sformatf("vec%0d mem_rd_req_vld", e), mem_rd_req_vld, tbl[e].exp_mvld);
            tick();
        end
        req_vld = '0; mem_rd_req_rdy = 1'b1;
        repeat (10) tick();
        chk("table drain", sb.size(), 0);

        // Single requester streaming 16 addresses
        rx0_dat.delete(); rx0_cyc.delete();
        base = rx_cnt[1] + rx_cnt[2] + rx_cnt[3];
        k[0] = 0; req_addr[0] = '0; req_vld = 4'b0001;
        for (int c = 0; c < 200 && rx0_dat.size() < 16; c++) begin
            tick();
            if (req_vld[0] && acc_mask[0]) begin
                k[0]++;
                if (k[0] == 16) req_vld[0] = 1'b0;
                else req_addr[0] = AW'(k[0]);
            end
        end
        chk("stream count", rx0_dat.size(), 16);
        for (int i = 0; i < 16 && i < rx0_dat.size(); i++)
            chk($sformatf("stream dat%0d", i), rx0_dat[i], 32'h100 + i);
        if (rx0_dat.size() == 16) chk("stream back-to-back", rx0_cyc[15] - rx0_cyc[0], 15);
        chk("stream others", rx_cnt[1] + rx_cnt[2] + rx_cnt[3], base);

        // All requesters continuously valid
        for (int i = 0; i < N; i++) begin
            rx_cnt[i] = 0; k[i] = 0; req_addr[i] = AW'(i * 64);
        end
        req_vld = '1;
        for (int c = 0; c < 400 && req_vld != '0; c++) begin
            tick();
            for (int i = 0; i < N; i++) if (req_vld[i] && acc_mask[i]) begin
                k[i]++;
                if (k[i] == 10) req_vld[i] = 1'b0;
                else req_addr[i] = AW'(i * 64 + k[i]);
            end
        end
        repeat (10) tick();
        for (int i = 0; i < N; i++) chk($sformatf("fair rx%0d", i), rx_cnt[i], 10);

        // Grant held while the memory stalls
        req_vld = 4'b0010; req_addr[1] = 9'h011;
        tick();
        req_vld = 4'b0100; req_addr[2] = 9'h055; req_addr[0] = 9'h066; req_addr[3] = 9'h077;
        mem_rd_req_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("hold addr", mem_rd_addr, 9'h055);
            chk("hold req_rdy", req_rdy, '0);
            chk("hold vld", mem_rd_req_vld, 1'b1);
            tick();
            if (c == 0) req_vld[0] = 1'b1;
        end
        mem_rd_req_rdy = 1'b1; req_vld[3] = 1'b1;
        #1; chk("hold release gnt2", req_rdy, 4'b0100);
        tick(); req_vld[2] = 1'b0;
        #1; chk("after hold gnt3", req_rdy, 4'b1000);
        tick(); req_vld[3] = 1'b0;
        #1; chk("after hold gnt0", req_rdy, 4'b0001);
        tick(); req_vld = '0;
        repeat (8) tick();

        // Head-of-line blocking
        rsp_rdy = 4'b1101;
        base = rx_cnt[3];
        req_vld = 4'b0010; req_addr[1] = 9'h130;
        tick();
        req_vld = 4'b1000; req_addr[3] = 9'h131;
        tick();
        req_vld = '0;
        for (int c = 0; c < 10; c++) begin
            #1; chk("hol blocked rsp3", rsp_vld[3], 1'b0);
            tick();
        end
        chk("hol rx3 none", rx_cnt[3], base);
        rsp_rdy = '1;
        for (int c = 0; c < 20 && rx_cnt[3] == base; c++) tick();
        chk("hol rx3 after release", rx_cnt[3], base + 1);

        // Reset with reads in flight
        rsp_rdy = '0; req_vld = 4'b0111;
        req_addr[0] = 9'h1F0; req_addr[1] = 9'h1F1; req_addr[2] = 9'h1F2;
        for (int c = 0; c < 20 && req_vld != '0; c++) begin
            tick();
            req_vld = req_vld & ~acc_mask;
        end
        repeat (4) tick();
        chk("inflight count", dut.w_count, 3);
        rst = 1'b1; req_vld = '0;
        tick();
        rst = 1'b0;
        chk("mid-reset req_rdy", req_rdy, '0);
        chk("mid-reset rsp_vld", rsp_vld, '0);
        chk("mid-reset mem_rd_req_vld", mem_rd_req_vld, 1'b0);
        chk("mid-reset mem_rd_dat_rdy", mem_rd_dat_rdy, 1'b0);
        chk("mid-reset count", dut.w_count, '0);
        rsp_rdy = '1;
        for (int c = 0; c < 6; c++) begin
            #1; chk("no stale rsp", rsp_vld, '0);
            tick();
        end
        base = rx_cnt[2];
        req_vld = 4'b0100; k[2] = 0; req_addr[2] = 9'h1A0;
        for (int c = 0; c < 40 && req_vld != '0; c++) begin
            tick();
            if (acc_mask[2]) begin
                k[2]++;
                if (k[2] == 4) req_vld[2] = 1'b0;
                else req_addr[2] = AW'(9'h1A0 + k[2]);
            end
        end
        repeat (10) tick();
        chk("post-reset rx2", rx_cnt[2], base + 4);

        // Credit limit with MAX_OUTSTANDING = 2
        b_req_vld = 4'b0001; b_req_addr[0] = 9'h005;
        issues = 0;
        for (int c = 0; c < 6; c++) begin
            #1; if (b_req_rdy[0]) issues++;
            tick();
        end
        chk("credit issues", issues, 2);
        chk("credit stalled vld", b_mem_rd_req_vld, 1'b0);
        b_mem_rd_dat_vld = 1'b1; b_mem_rd_dat = 32'hABC; b_rsp_rdy = '1;
        #1;
        chk("credit pop rdy", b_mem_rd_dat_rdy, 1'b1);
        chk("credit pop rsp_vld", b_rsp_vld, 4'b0001);
        chk("credit pop rsp_dat", b_rsp_dat, 32'hABC);
        chk("credit vld before pop", b_mem_rd_req_vld, 1'b0);
        tick();
        b_mem_rd_dat_vld = 1'b0;
        #1; chk("credit resume", b_mem_rd_req_vld, 1'b1);
        b_req_vld = '0;
        tick();

        // Randomized traffic against the reference model
        for (int c = 0; c < 1500; c++) begin
            mem_rd_req_rdy = ($urandom % 4) != 0;
            rsp_rdy = N'($urandom % 16) | N'($urandom % 16);
            for (int i = 0; i < N; i++) if (!req_vld[i] || acc_mask[i]) begin
                req_vld[i]  = ($urandom % 3) != 0;
                req_addr[i] = AW'($urandom % 512);
            end
            tick();
        end
        req_vld = '0; rsp_rdy = '1; mem_rd_req_rdy = 1'b1;
        repeat (30) tick();
        chk("random drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
